// File: rtl/signal_measure_pkg.sv
// signal_measure_pkg: shared state encoding and sample range constants for the extremes tracker
package signal_measure_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

    function automatic logic [63:0] sample_max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sample_max_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/signal_extremes_tracker_extreme_update.sv
// extreme_update: next running max/min for one sample, seeded from the sample at window start
module extreme_update #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] runMax,
    input  logic signed [W-1:0] runMin,
    input  logic signed [W-1:0] sample,
    input  logic                init,
    output logic signed [W-1:0] nextMax,
    output logic signed [W-1:0] nextMin
);

    // non-strict compares so equal samples are taken as the new extreme
    always_comb begin
        nextMax = (init || sample >= runMax) ? sample : runMax;
        nextMin = (init || sample <= runMin) ? sample : runMin;
    end

endmodule

// File: rtl/signal_extremes_tracker.sv
// signal_extremes_tracker: windowed max/min/peak-to-peak of display-Y samples; SIGNAL_MEAN_EN adds a window mean
module signal_extremes_tracker
    import signal_measure_pkg::*;
#(
    parameter int DISPLAY_Y_BITS = 12,
    parameter int WINDOW_BITS    = 10
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             run,
    input  logic                             clear,
    input  logic                             hold,
    input  logic                             sampleValid,
    input  logic signed [DISPLAY_Y_BITS-1:0] sample,
    output logic signed [DISPLAY_Y_BITS-1:0] signalMax,
    output logic signed [DISPLAY_Y_BITS-1:0] signalMin,
    output logic        [DISPLAY_Y_BITS:0]   peakToPeak,
    output logic signed [DISPLAY_Y_BITS-1:0] signalMean,
    output logic                             resultValid
);

    localparam logic signed [DISPLAY_Y_BITS-1:0] POS = DISPLAY_Y_BITS'(sample_max_pos(DISPLAY_Y_BITS));
    localparam logic signed [DISPLAY_Y_BITS-1:0] NEG = DISPLAY_Y_BITS'(sample_max_neg(DISPLAY_Y_BITS));

    state_t                           state;
    logic        [WINDOW_BITS-1:0]    count;
    logic signed [DISPLAY_Y_BITS-1:0] runMax, runMin, nextMax, nextMin, stageMax, stageMin;
    logic                             restart, publish;

    assign restart = (clear && state != IDLE) || !run;
    assign publish = state == PUBLISH && !clear && !hold;

    extreme_update #(.W(DISPLAY_Y_BITS)) u_update (
        .runMax (runMax),
        .runMin (runMin),
        .sample (sample),
        .init   (state == PUBLISH),
        .nextMax(nextMax),
        .nextMin(nextMin)
    );

    // window sequencing, running extremes, staging and published outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            runMax      <= NEG;
            runMin      <= POS;
            stageMax    <= '0;
            stageMin    <= '0;
            signalMax   <= '0;
            signalMin   <= '0;
            peakToPeak  <= '0;
            resultValid <= 1'b0;
        end else begin
            resultValid <= publish;
            if (publish) begin
                signalMax  <= stageMax;
                signalMin  <= stageMin;
                peakToPeak <= {stageMax[DISPLAY_Y_BITS-1], stageMax} - {stageMin[DISPLAY_Y_BITS-1], stageMin};
            end
            if (restart) begin
                state  <= run ? ACCUM : IDLE;
                count  <= '0;
                runMax <= NEG;
                runMin <= POS;
            end else if (state == IDLE) begin
                state <= ACCUM;
            end else if (sampleValid && &count) begin
                stageMax <= nextMax;
                stageMin <= nextMin;
                runMax   <= NEG;
                runMin   <= POS;
                count    <= '0;
                state    <= PUBLISH;
            end else begin
                state <= ACCUM;
                if (sampleValid) begin
                    runMax <= nextMax;
                    runMin <= nextMin;
                    count  <= count + 1'b1;
                end
            end
        end
    end

`ifdef SIGNAL_MEAN_EN
    logic signed [DISPLAY_Y_BITS+WINDOW_BITS-1:0] acc, accNext;
    logic signed [DISPLAY_Y_BITS-1:0]             stageMean;

    assign accNext = acc + {{WINDOW_BITS{sample[DISPLAY_Y_BITS-1]}}, sample};

    // window sum; the top bits of the sum are the floor-divided mean
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            stageMean  <= '0;
            signalMean <= '0;
        end else begin
            if (publish)
                signalMean <= stageMean;
            if (restart || state == IDLE) begin
                acc <= '0;
            end else if (sampleValid && &count) begin
                stageMean <= accNext[DISPLAY_Y_BITS+WINDOW_BITS-1:WINDOW_BITS];
                acc       <= '0;
            end else if (sampleValid) begin
                acc <= accNext;
            end
        end
    end
`else
    assign signalMean = '0;
`endif

endmodule

// File: tb/tb_signal_extremes_tracker.sv
// tb_signal_extremes_tracker: directed checks of windowed extremes with WINDOW_BITS=2
module tb_signal_extremes_tracker;
    import signal_measure_pkg::*;

`ifdef SIGNAL_MEAN_EN
    localparam bit MEAN_ON = 1'b1;
`else
    localparam bit MEAN_ON = 1'b0;
`endif

    logic               clock = 1'b0, reset_n = 1'b0, run = 1'b0, clear = 1'b0, hold = 1'b0, sampleValid = 1'b0;
    logic signed [11:0] sample = '0;
    logic signed [11:0] signalMax, signalMin, signalMean;
    logic        [12:0] peakToPeak;
    logic               resultValid;
    int                 assert_cnt = 0, fail_cnt = 0;

    signal_extremes_tracker #(.DISPLAY_Y_BITS(12), .WINDOW_BITS(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .clear      (clear),
        .hold       (hold),
        .sampleValid(sampleValid),
        .sample     (sample),
        .signalMax  (signalMax),
        .signalMin  (signalMin),
        .peakToPeak (peakToPeak),
        .signalMean (signalMean),
        .resultValid(resultValid)
    );

    always #5 clock = ~clock;

    function automatic logic signed [11:0] em(input int v);
        return MEAN_ON ? 12'(v) : 12'sd0;
    endfunction

    task automatic send(input logic v, input int s);
        @(negedge clock);
        sampleValid = v;
        sample      = 12'(s);
    endtask

    task automatic test_reset;
        #3;
        assert_cnt++; if (signalMax !== 12'sd0) begin fail_cnt++; $display("FAIL reset_max: got %0d expected 0", signalMax); end
        assert_cnt++; if (signalMin !== 12'sd0) begin fail_cnt++; $display("FAIL reset_min: got %0d expected 0", signalMin); end
        assert_cnt++; if (peakToPeak !== 13'd0) begin fail_cnt++; $display("FAIL reset_p2p: got %0d expected 0", peakToPeak); end
        assert_cnt++; if (resultValid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid: got %b expected 0", resultValid); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        assert_cnt++; if (dut.state !== IDLE) begin fail_cnt++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_basic;
        @(negedge clock);
        run = 1'b1;
        send(1, 5); send(1, -3); send(1, 100); send(1, 7); send(0, 0);
        assert_cnt++; if (resultValid !== 1'b0) begin fail_cnt++; $display("FAIL basic_early: got %b expected 0", resultValid); end
        @(negedge clock);
        assert_cnt++; if (resultValid !== 1'b1) begin fail_cnt++; $display("FAIL basic_valid: got %b expected 1", resultValid); end
        assert_cnt++; if (signalMax !== 12'sd100) begin fail_cnt++; $display("FAIL basic_max: got %0d expected 100", signalMax); end
        assert_cnt++; if (signalMin !== -12'sd3) begin fail_cnt++; $display("FAIL basic_min: got %0d expected -3", signalMin); end
        assert_cnt++; if (peakToPeak !== 13'd103) begin fail_cnt++; $display("FAIL basic_p2p: got %0d expected 103", peakToPeak); end
        assert_cnt++; if (signalMean !== em(27)) begin fail_cnt++; $display("FAIL basic_mean: got %0d expected %0d", signalMean, em(27)); end
        @(negedge clock);
        assert_cnt++; if (resultValid !== 1'b0) begin fail_cnt++; $display("FAIL basic_pulse_len: got %b expected 0", resultValid); end
        assert_cnt++; if (signalMax !== 12'sd100) begin fail_cnt++; $display("FAIL basic_stable: got %0d expected 100", signalMax); end
    endtask

    task automatic test_full_scale;
        send(1, 2047); send(1, -2048); send(1, 0); send(1, 0); send(0, 0);
        @(negedge clock);
        assert_cnt++; if (resultValid !== 1'b1) begin fail_cnt++; $display("FAIL full_valid: got %b expected 1", resultValid); end
        assert_cnt++; if (signalMax !== 12'sd2047) begin fail_cnt++; $display("FAIL full_max: got %0d expected 2047", signalMax); end
        assert_cnt++; if (signalMin !== -12'sd2048) begin fail_cnt++; $display("FAIL full_min: got %0d expected -2048", signalMin); end
        assert_cnt++; if (peakToPeak !== 13'd4095) begin fail_cnt++; $display("FAIL full_p2p: got %0d expected 4095", peakToPeak); end
        assert_cnt++; if (signalMean !== em(-1)) begin fail_cnt++; $display("FAIL full_mean: got %0d expected %0d", signalMean, em(-1)); end
    endtask

    task automatic test_back_to_back;
        for (int i = 1; i <= 5; i++) send(1, i);
        @(negedge clock);
        assert_cnt++; if (resultValid !== 1'b1) begin fail_cnt++; $display("FAIL b2b_valid1: got %b expected 1", resultValid); end
        assert_cnt++; if (signalMax !== 12'sd4) begin fail_cnt++; $display("FAIL b2b_max1: got %0d expected 4", signalMax); end
        assert_cnt++; if (signalMin !== 12'sd1) begin fail_cnt++; $display("FAIL b2b_min1: got %0d expected 1", signalMin); end
        assert_cnt++; if (signalMean !== em(2)) begin fail_cnt++; $display("FAIL b2b_mean1: got %0d expected %0d", signalMean, em(2)); end
        sample = 12'sd6;
        send(1, 7); send(1, 8); send(0, 0);
        @(negedge clock);
        assert_cnt++; if (resultValid !== 1'b1) begin fail_cnt++; $display("FAIL b2b_valid2: got %b expected 1", resultValid); end
        assert_cnt++; if (signalMax !== 12'sd8) begin fail_cnt++; $display("FAIL b2b_max2: got %0d expected 8", signalMax); end
        assert_cnt++; if (signalMin !== 12'sd5) begin fail_cnt++; $display("FAIL b2b_min2: got %0d expected 5", signalMin); end
        assert_cnt++; if (peakToPeak !== 13'd3) begin fail_cnt++; $display("FAIL b2b_p2p2: got %0d expected 3", peakToPeak); end
        assert_cnt++; if (signalMean !== em(6)) begin fail_cnt++; $display("FAIL b2b_mean2: got %0d expected %0d", signalMean, em(6)); end
    endtask

    task automatic test_hold;
        send(1, 10);
        hold = 1'b1;
        send(1, 20); send(1, 30); send(1, 40); send(0, 0);
        @(negedge clock);
        assert_cnt++; if (resultValid !== 1'b0) begin fail_cnt++; $display("FAIL hold_valid: got %b expected 0", resultValid); end
        assert_cnt++; if (signalMax !== 12'sd8) begin fail_cnt++; $display("FAIL hold_max: got %0d expected 8", signalMax); end
        assert_cnt++; if (signalMin !== 12'sd5) begin fail_cnt++; $display("FAIL hold_min: got %0d expected 5", signalMin); end
        send(1, -1);
        hold = 1'b0;
        send(1, -2); send(1, -3); send(1, -4); send(0, 0);
        @(negedge clock);
        assert_cnt++; if (resultValid !== 1'b1) begin fail_cnt++; $display("FAIL unhold_valid: got %b expected 1", resultValid); end
        assert_cnt++; if (signalMax !== -12'sd1) begin fail_cnt++; $display("FAIL unhold_max: got %0d expected -1", signalMax); end
        assert_cnt++; if (signalMin !== -12'sd4) begin fail_cnt++; $display("FAIL unhold_min: got %0d expected -4", signalMin); end
        assert_cnt++; if (peakToPeak !== 13'd3) begin fail_cnt++; $display("FAIL unhold_p2p: got %0d expected 3", peakToPeak); end
        assert_cnt++; if (signalMean !== em(-3)) begin fail_cnt++; $display("FAIL unhold_mean: got %0d expected %0d", signalMean, em(-3)); end
    endtask

    task automatic test_clear;
        send(1, 50); send(1, 60);
        @(negedge clock);
        clear = 1'b1; sampleValid = 1'b1; sample = 12'sd999;
        send(1, 11);
        clear = 1'b0;
        send(1, 12); send(1, 13); send(1, 14); send(0, 0);
        @(negedge clock);
        assert_cnt++; if (resultValid !== 1'b1) begin fail_cnt++; $display("FAIL clear_valid: got %b expected 1", resultValid); end
        assert_cnt++; if (signalMax !== 12'sd14) begin fail_cnt++; $display("FAIL clear_max: got %0d expected 14", signalMax); end
        assert_cnt++; if (signalMin !== 12'sd11) begin fail_cnt++; $display("FAIL clear_min: got %0d expected 11", signalMin); end
        assert_cnt++; if (signalMean !== em(12)) begin fail_cnt++; $display("FAIL clear_mean: got %0d expected %0d", signalMean, em(12)); end
        send(1, 1); send(1, 2); send(1, 3); send(1, 4);
        @(negedge clock);
        sampleValid = 1'b0; clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        assert_cnt++; if (resultValid !== 1'b0) begin fail_cnt++; $display("FAIL clear_cancel: got %b expected 0", resultValid); end
        assert_cnt++; if (signalMax !== 12'sd14) begin fail_cnt++; $display("FAIL clear_keep: got %0d expected 14", signalMax); end
        @(negedge clock);
        assert_cnt++; if (resultValid !== 1'b0) begin fail_cnt++; $display("FAIL clear_late: got %b expected 0", resultValid); end
    endtask

    task automatic test_run_stop;
        send(1, 70); send(1, 80);
        @(negedge clock);
        run = 1'b0; sampleValid = 1'b1; sample = 12'sd2000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            assert_cnt++; if (resultValid !== 1'b0) begin fail_cnt++; $display("FAIL stop_valid%0d: got %b expected 0", i, resultValid); end
        end
        run = 1'b1;
        send(1, 1); send(1, 2); send(1, 3); send(1, 4); send(0, 0);
        @(negedge clock);
        assert_cnt++; if (resultValid !== 1'b1) begin fail_cnt++; $display("FAIL restart_valid: got %b expected 1", resultValid); end
        assert_cnt++; if (signalMax !== 12'sd4) begin fail_cnt++; $display("FAIL restart_max: got %0d expected 4", signalMax); end
        assert_cnt++; if (signalMin !== 12'sd1) begin fail_cnt++; $display("FAIL restart_min: got %0d expected 1", signalMin); end
        assert_cnt++; if (signalMean !== em(2)) begin fail_cnt++; $display("FAIL restart_mean: got %0d expected %0d", signalMean, em(2)); end
    endtask

    task automatic test_equal_and_async_reset;
        for (int i = 0; i < 4; i++) send(1, 3);
        send(0, 0);
        @(negedge clock);
        assert_cnt++; if (resultValid !== 1'b1) begin fail_cnt++; $display("FAIL equal_valid: got %b expected 1", resultValid); end
        assert_cnt++; if (signalMax !== 12'sd3 || signalMin !== 12'sd3) begin fail_cnt++; $display("FAIL equal_maxmin: got %0d/%0d expected 3/3", signalMax, signalMin); end
        assert_cnt++; if (peakToPeak !== 13'd0) begin fail_cnt++; $display("FAIL equal_p2p: got %0d expected 0", peakToPeak); end
        #2 reset_n = 1'b0;
        #1;
        assert_cnt++; if (resultValid !== 1'b0) begin fail_cnt++; $display("FAIL async_valid: got %b expected 0", resultValid); end
        assert_cnt++; if (signalMax !== 12'sd0 || signalMin !== 12'sd0) begin fail_cnt++; $display("FAIL async_maxmin: got %0d/%0d expected 0/0", signalMax, signalMin); end
        assert_cnt++; if (peakToPeak !== 13'd0 || signalMean !== 12'sd0) begin fail_cnt++; $display("FAIL async_p2p_mean: got %0d/%0d expected 0/0", peakToPeak, signalMean); end
        run = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        assert_cnt++; if (dut.state !== IDLE) begin fail_cnt++; $display("FAIL async_state: got %0d expected %0d", dut.state, IDLE); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full_scale;
        test_back_to_back;
        test_hold;
        test_clear;
        test_run_stop;
        test_equal_and_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/signal_extremes_tracker.md
Name: signal_extremes_tracker

Overview:
- Upstream measurement stage for the on-screen voltage readouts.
- Accumulates the running maximum and minimum of the signed display-Y sample stream over a fixed window of 2^WINDOW_BITS accepted samples.
- At the end of each window it publishes max, min and peak-to-peak with a one-cycle valid pulse.
- signalMax / signalMin feed the signal-to-voltage converters that drive the max/min character readouts.

Parameters:
- DISPLAY_Y_BITS, 12, width of signed sample and of signalMax/signalMin.
- WINDOW_BITS, 10, log2 of window length in accepted samples (min 1).

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- run  input  1  1 = accept samples; 0 = go to IDLE, samples ignored
- clear  input  1  synchronous restart of the current window
- hold  input  1  1 = completed windows are not published (scope frozen)
- sampleValid  input  1  sample qualifier
- sample  input  DISPLAY_Y_BITS signed  display-Y sample
- signalMax  output  DISPLAY_Y_BITS signed  published window maximum
- signalMin  output  DISPLAY_Y_BITS signed  published window minimum
- peakToPeak  output  DISPLAY_Y_BITS+1 unsigned  signalMax - signalMin
- signalMean  output  DISPLAY_Y_BITS signed  published window mean (see Optional Feature)
- resultValid  output  1  one-cycle pulse when outputs update

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE; sample counter=0.
  - runMax=most negative value (-2^(DISPLAY_Y_BITS-1)); runMin=most positive value.
  - All outputs 0.
- States: IDLE, ACCUM, PUBLISH.
- IDLE:
  - samples ignored; running registers held at their init values.
  - run=1 -> ACCUM next cycle.
- ACCUM:
  - Each cycle with sampleValid=1: runMax=max(runMax,sample), runMin=min(runMin,sample), counter+1.
  - When a sample is accepted with counter=2^WINDOW_BITS-1, the window is complete:
    - final max/min (including that sample) go to staging registers;
    - counter wraps to 0; running registers re-init; state -> PUBLISH.
- PUBLISH (exactly 1 cycle):
  - If hold=0: signalMax, signalMin, peakToPeak, signalMean load from staging; resultValid=1.
  - If hold=1: outputs keep their old values; resultValid=0.
  - A sample valid in this cycle is accepted as sample 0 of the next window. No sample is ever lost between windows.
  - Next state is ACCUM, or IDLE if run=0.
- Latency: resultValid asserts on the cycle after the edge that accepted the last window sample. Outputs are stable between pulses.
- peakToPeak: computed from DISPLAY_Y_BITS+1 sign-extended operands; never negative, never overflows. Full scale gives 2^DISPLAY_Y_BITS - 1.
- clear=1, any state except IDLE:
  - counter=0, running registers re-init; a pending PUBLISH is cancelled (no pulse).
  - A sample in the same cycle is dropped; clear wins over sampleValid.
  - Published outputs are unchanged.
- run=0 mid-window: -> IDLE next cycle; partial window discarded. Counter and running registers re-init.
- Priority: reset_n > clear > run=0 > sample update.
- Equal samples: comparisons are non-strict, so an all-constant window gives max=min=value and peakToPeak=0.

Optional Feature:
- Macro: SIGNAL_MEAN_EN.
- Defined:
  - Signed accumulator of DISPLAY_Y_BITS+WINDOW_BITS bits sums the accepted samples.
  - Accumulator follows the same re-init and clear rules as runMax/runMin.
  - At window end, signalMean = sum >>> WINDOW_BITS (arithmetic shift, floor toward -inf). It is published with the other outputs.
- Undefined: no accumulator; signalMean tied to 0. All other behaviour is identical.

Decomposition:
- Package signal_measure_pkg contains:
  - the state enum (IDLE, ACCUM, PUBLISH);
  - a function for the most-positive and most-negative sample constants for a given width.
- Sub-module extreme_update: combinational.
  - Inputs: runMax, runMin, sample, init.
  - Outputs: next max/min.
  - When init=1 the outputs equal the sample.
  - Used for both the ACCUM update and the window-start-in-PUBLISH case.

Test Plan (WINDOW_BITS=2, DISPLAY_Y_BITS=12):
- reset_n low mid-operation -> all outputs 0, resultValid 0 immediately (asynchronous); after release, state IDLE.
- run=1, samples 5,-3,100,7 back-to-back -> one cycle after the 4th sample: resultValid=1, signalMax=100, signalMin=-3, peakToPeak=103. With SIGNAL_MEAN_EN, signalMean=27 (109>>>2).
- Samples 2047,-2048,0,0 -> signalMax=2047, signalMin=-2048, peakToPeak=4095.
- 8 continuous samples 1..8, with sample 5 arriving in the PUBLISH cycle -> two pulses, windows {1..4} and {5..8}: max 4/8, min 1/5.
- hold=1 across a window end -> no resultValid, outputs keep prior values. hold=0 for the next window -> normal publish.
- clear asserted together with the 3rd sample -> that sample dropped, counter restarts; the publish uses only the 4 samples after clear. run=0 after 2 samples -> no pulse; restart gives a fresh window.
